// File: rtl/led_seq_pkg.sv
// Shared encodings, start/terminal patterns and the per-mode next-pattern
// function for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_ROTATE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  localparam logic [7:0] START_BOUNCE = 8'h80;
  localparam logic [7:0] START_FILL   = 8'h00;
  localparam logic [7:0] START_BLINK  = 8'h00;
  localparam logic [7:0] START_ROTATE = 8'h80;

  // A pass completes when the next pattern equals these (BOUNCE only when
  // arriving from the left).
  localparam logic [7:0] TERM_BOUNCE = 8'h80;
  localparam logic [7:0] TERM_FILL   = 8'h00;
  localparam logic [7:0] TERM_BLINK  = 8'h00;
  localparam logic [7:0] TERM_ROTATE = 8'h80;

  typedef struct packed {
    logic [7:0] led;
    dir_t       dir;
    logic       pass_done;
  } step_t;

  function automatic logic [7:0] start_pattern(input mode_t m);
    case (m)
      MODE_BOUNCE: return START_BOUNCE;
      MODE_FILL:   return START_FILL;
      MODE_BLINK:  return START_BLINK;
      default:     return START_ROTATE;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [7:0] v);
    logic [7:0] m;
    m = v & (v - 8'd1);
    return (v != 8'd0) && (m == 8'd0);
  endfunction

  function automatic step_t next_step(input mode_t m, input logic [7:0] led, input dir_t dir);
    step_t      s;
    logic       legal;
    logic [7:0] term;
    logic [7:0] inv;
    logic [7:0] msk;
    s.led       = led;
    s.dir       = DIR_RIGHT;
    s.pass_done = 1'b0;
    legal       = 1'b0;
    term        = 8'h00;
    inv         = ~led;
    msk         = inv & (inv + 8'd1);
    case (m)
      MODE_BOUNCE: begin
        term  = TERM_BOUNCE;
        legal = is_onehot(led) && !(dir == DIR_LEFT && led == 8'h80);
        if (dir == DIR_RIGHT) begin
          if (led == 8'h01) begin
            s.led = 8'h02;
            s.dir = DIR_LEFT;
          end else begin
            s.led = led >> 1;
          end
        end else begin
          s.led = led << 1;
          s.dir = (s.led == 8'h80) ? DIR_RIGHT : DIR_LEFT;
        end
      end
      MODE_FILL: begin
        // Legal fill values have the inverted pattern as a low-order mask.
        term  = TERM_FILL;
        legal = (msk == 8'd0);
        s.led = (led == 8'hFF) ? 8'h00 : {1'b1, led[7:1]};
      end
      MODE_BLINK: begin
        term  = TERM_BLINK;
        legal = (led == 8'h00) || (led == 8'hFF);
        s.led = ~led;
      end
      default: begin
        term  = TERM_ROTATE;
        legal = is_onehot(led);
        s.led = {led[0], led[7:1]};
      end
    endcase
    if (!legal) begin
      s.led = start_pattern(m);
      s.dir = DIR_RIGHT;
    end else begin
      s.pass_done = (s.led == term) && (m != MODE_BOUNCE || dir == DIR_LEFT);
    end
    return s;
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Step prescaler: adv pulses once every (TICK_DIV >> speed) enabled cycles;
// a speed change or an external clear restarts the count.
module led_tick_prescaler #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       adv
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] count;
  logic [CW-1:0] term;
  logic [1:0]    speed_q;
  logic          speed_chg;

  always_comb begin
    term      = CW'((TICK_DIV >> speed) - 32'd1);
    speed_chg = (speed != speed_q);
    adv       = en && !speed_chg && (count == term);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      speed_q <= speed;
    end else begin
      speed_q <= speed;
      if (clr || speed_chg || adv) begin
        count <= '0;
      end else if (en) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// 8-LED pattern sequencer: steps bounce/fill/blink/rotate at the prescaler
// rate and advances the mode on a user pulse or after AUTO_PASSES passes.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 25_000_000,
  parameter int unsigned AUTO_PASSES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       mode_next,
  input  logic       auto_en,
  input  logic [1:0] speed,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       step
);

  localparam int unsigned   PW       = $clog2(AUTO_PASSES + 1);
  localparam logic [PW-1:0] PASS_MAX = PW'(AUTO_PASSES);

  logic [7:0]    led_q;
  mode_t         mode_q;
  dir_t          dir_q;
  logic [PW-1:0] pass_cnt;
  logic          step_q;
  logic          adv;
  logic          mode_adv;
  mode_t         mode_inc;
  step_t         nxt;

  led_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (mode_adv),
    .speed(speed),
    .adv  (adv)
  );

  always_comb begin
    nxt      = next_step(mode_q, led_q, dir_q);
    mode_adv = mode_next || (auto_en && pass_cnt == PASS_MAX);
    mode_inc = mode_t'(mode_q + 2'd1);
  end

  // A mode advance outranks a coincident step; that step is discarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q    <= START_BOUNCE;
      mode_q   <= MODE_BOUNCE;
      dir_q    <= DIR_RIGHT;
      pass_cnt <= '0;
      step_q   <= 1'b0;
    end else if (mode_adv) begin
      led_q    <= start_pattern(mode_inc);
      mode_q   <= mode_inc;
      dir_q    <= DIR_RIGHT;
      pass_cnt <= '0;
      step_q   <= 1'b0;
    end else begin
      step_q <= adv;
      if (adv) begin
        led_q <= nxt.led;
        dir_q <= nxt.dir;
        if (nxt.pass_done && pass_cnt != PASS_MAX) begin
          pass_cnt <= pass_cnt + 1'b1;
        end
      end
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with TICK_DIV=8, AUTO_PASSES=2;
// expected LED values are queued by hand and popped on each step pulse.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       mode_next = 1'b0;
  logic       auto_en = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       step;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .TICK_DIV   (8),
    .AUTO_PASSES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode_next(mode_next),
    .auto_en  (auto_en),
    .speed    (speed),
    .led      (led),
    .mode     (mode),
    .step     (step)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    mode_next = 1'b1;
    tick();
    mode_next = 1'b0;
  endtask

  // Wait (bounded) for the next step pulse, then check gap and LED value.
  task automatic expect_step(input string tag, input int gap);
    int n = 0;
    logic [7:0] e;
    do begin
      tick();
      n++;
    end while (!step && n < 200);
    check({tag, "_gap"}, n, gap);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_led"}, led, e);
  endtask

  task automatic check_idle(input string tag, input logic [7:0] e_led, input logic [1:0] e_mode);
    check({tag, "_led"}, led, e_led);
    check({tag, "_mode"}, mode, e_mode);
    check({tag, "_step"}, step, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    check_idle("reset", 8'h80, 2'd0);
    reset = 1'b1;

    // Full bounce pass at speed 0.
    exp_q = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
              8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 14; i++) expect_step("bounce", 8);
    check("bounce_mode", mode, 2'd0);

    // Speed changes: one cleared cycle, then the new period.
    speed = 2'd3;
    exp_q = '{8'h40, 8'h20, 8'h10};
    expect_step("spd3_first", 2);
    expect_step("spd3", 1);
    expect_step("spd3", 1);
    speed = 2'd2;
    exp_q = '{8'h08, 8'h04};
    expect_step("spd2_first", 3);
    expect_step("spd2", 2);
    speed = 2'd0;
    exp_q = '{8'h02};
    expect_step("spd0_first", 9);

    // mode_next coincides with a pending step: step dropped.
    repeat (7) tick();
    pulse_mode();
    check_idle("mode_vs_adv", 8'h00, 2'd1);
    exp_q = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
    for (int i = 0; i < 9; i++) expect_step("fill", 8);
    check("fill_mode", mode, 2'd1);

    // Reset mid-fill at E0.
    exp_q = '{8'h80, 8'hC0, 8'hE0};
    for (int i = 0; i < 3; i++) expect_step("fill2", 8);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle("reset_mid", 8'h80, 2'd0);

    // Freeze with en=0 at led=10, then a freeze mid-count.
    exp_q = '{8'h40, 8'h20, 8'h10};
    for (int i = 0; i < 3; i++) expect_step("bounce2", 8);
    en = 1'b0;
    repeat (50) tick();
    check_idle("frozen", 8'h10, 2'd0);
    en = 1'b1;
    exp_q = '{8'h08};
    expect_step("resume", 8);
    repeat (3) tick();
    en = 1'b0;
    repeat (20) tick();
    check_idle("frozen2", 8'h08, 2'd0);
    en = 1'b1;
    exp_q = '{8'h04};
    expect_step("resume2", 5);

    // Auto advance from BLINK after two passes, with a coincident mode_next.
    pulse_mode();
    pulse_mode();
    check_idle("to_blink", 8'h00, 2'd2);
    speed   = 2'd3;
    auto_en = 1'b1;
    exp_q = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    expect_step("blink_first", 2);
    for (int i = 0; i < 3; i++) expect_step("blink", 1);
    pulse_mode();
    check_idle("auto_to_rot", 8'h80, 2'd3);
    exp_q = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    for (int i = 0; i < 16; i++) expect_step("rotate", 1);
    check("rotate_mode", mode, 2'd3);
    tick();
    check_idle("auto_to_bounce", 8'h80, 2'd0);

    // Manual wrap 3 -> 0, and mode changes while frozen.
    auto_en = 1'b0;
    pulse_mode();
    pulse_mode();
    pulse_mode();
    check("wrap_pre_mode", mode, 2'd3);
    check("wrap_pre_led", led, 8'h80);
    en = 1'b0;
    pulse_mode();
    repeat (5) tick();
    check_idle("wrap_frozen", 8'h80, 2'd0);
    pulse_mode();
    repeat (5) tick();
    check_idle("fill_frozen", 8'h00, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Controller and scheduler for the 8-LED bank on the lab FPGA board.
- A prescaler paces the steps. The block sequences one of four patterns: bounce (ping-pong), fill, blink and rotate.
- The mode changes on a user pulse, or automatically after a programmable number of completed passes.
- Sits between the debounced button/switch inputs and the board LED pins.

Parameters:
- TICK_DIV, 25_000_000: base step period in clk cycles at speed=0. Must be ≥8.
- AUTO_PASSES, 2: number of completed passes before an auto mode advance. Must be ≥1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  run enable. 0 freezes the prescaler and the LEDs.
- mode_next  input  1  single-cycle pulse (already debounced); advances the mode.
- auto_en  input  1  enables automatic mode advance.
- speed  input  2  step period = TICK_DIV >> speed cycles.
- led  output  8  LED bank; bit 7 is leftmost.
- mode  output  2  current mode: 0 BOUNCE, 1 FILL, 2 BLINK, 3 ROTATE.
- step  output  1  high for exactly the one cycle in which led first shows a new step value.

Behaviour:
- Reset (reset=0 at an edge), with priority over every other input, including mid-pass:
  - led=8'h80, mode=0, dir=right, prescaler=0, pass_cnt=0, step=0.
- Prescaler:
  - Counts 0..(TICK_DIV>>speed)-1 while en=1, and holds while en=0.
  - An internal adv strobe fires on the edge where the count is at terminal and en=1; the count wraps to 0 on that edge.
  - Any change of speed (compared against a registered copy) clears the count that cycle, with no adv.
- Step update: at the edge where adv=1, led takes its next value; step registers adv, so step=1 in the following cycle.
- BOUNCE:
  - Starts at 80, shifts right to 01, then shifts left back to 80, tracked by a dir flag.
  - A pass completes on the 02→80 return; 14 steps per pass.
- FILL:
  - Sequence 00→80→C0→E0→…→FF→00.
  - A pass completes on FF→00; 9 steps per pass.
- BLINK:
  - Sequence 00→FF→00.
  - A pass completes on FF→00; 2 steps per pass.
- ROTATE:
  - Rotates right 80→40→…→01→80.
  - A pass completes on 01→80; 8 steps per pass.
- Illegal led value for the current mode (e.g. zero or non-one-hot in BOUNCE/ROTATE, non-thermometer in FILL): the next adv loads the mode's start pattern.
- Start patterns: BOUNCE 80, FILL 00, BLINK 00, ROTATE 80.
- Mode advance, on a mode_next pulse or when auto_en=1 and pass_cnt reaches AUTO_PASSES:
  - On the next edge: mode=(mode+1) mod 4 (3 wraps to 0).
  - led=start pattern of the new mode, dir=right, pass_cnt=0, prescaler=0, step=0.
  - Takes priority over an adv in the same cycle. The pending step is dropped.
- Simultaneous mode_next and auto advance in one cycle: the mode advances exactly once.
- Mode advance works with en=0; the LEDs then show the start pattern, frozen.
- pass_cnt:
  - Increments on each completed pass and saturates at AUTO_PASSES.
  - Counts even with auto_en=0. Setting auto_en=1 while saturated advances the mode on the next edge.

Decomposition:
- Package led_seq_pkg holds:
  - the 2-bit mode encoding constants;
  - the four start patterns;
  - the pass-terminal values (BOUNCE 80 from the left, FILL 00, BLINK 00, ROTATE 80);
  - the function that returns the next pattern given mode, led and dir.
- One sub-module, led_tick_prescaler (clk, reset, en, speed → adv), parameterised by TICK_DIV; it includes the speed-change clear.

Test Plan:
- TICK_DIV=8, speed=0, en=1; release reset → led 80,40,20,…,01,02,…,80 with step pulses every 8 cycles; mode=0.
- speed 0→3 mid-run → no step for 1 cycle, then step every cycle; speed=2 → every 2 cycles.
- Pulse mode_next in the same cycle as a pending adv → mode=1, led=00, step=0; FILL then runs 80,C0,…,FF,00.
- auto_en=1, AUTO_PASSES=2, speed=3, mode=2 → after led FF,00,FF,00 the mode becomes 3 and led=80; after 16 further steps the mode becomes 0.
- en=0 for 50 cycles mid-BOUNCE at led=10 → led and prescaler frozen; after en=1 the sequence resumes exactly 8 cycles later with 08.
- Assert reset for 1 cycle mid-FILL at led=E0 → led=80, mode=0, step=0; mode_next at mode=3 wraps to 0.
